// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and geometry for the sprite move sequencer
package sprite_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LOAD,
    S_DRAW,
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam int SPRITE_W  = 4;
  localparam int SPRITE_H  = 4;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int PHASE_LEN = SPRITE_W * SPRITE_H;
  localparam int CNT_W     = $clog2(PHASE_LEN);

  // Signed per-axis step; opposing requests cancel to zero.
  function automatic logic signed [8:0] axis_step(input logic pos, input logic neg, input int step);
    if (pos && !neg) return $signed(9'(step));
    if (neg && !pos) return -$signed(9'(step));
    return '0;
  endfunction

endpackage

// File: rtl/sprite_pos_clamp.sv
// rtl/sprite_pos_clamp.sv - applies a signed step to the origin and clamps it to the screen
module sprite_pos_clamp #(
  parameter int X_MAX = 156,
  parameter int Y_MAX = 116
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  output logic [7:0]        nx,
  output logic [6:0]        ny,
  output logic              moved
);

  logic signed [8:0] sx;
  logic signed [8:0] sy;

  // 9-bit signed sums so stepping below 0 or past the top never wraps.
  always_comb begin
    sx = $signed({1'b0, x}) + dx;
    sy = $signed({2'b00, y}) + dy;
    if (sx[8])                          nx = '0;
    else if (sx > $signed(9'(X_MAX)))   nx = 8'(X_MAX);
    else                                nx = sx[7:0];
    if (sy[8])                          ny = '0;
    else if (sy > $signed(9'(Y_MAX)))   ny = 7'(Y_MAX);
    else                                ny = sy[6:0];
    moved = (nx != x) || (ny != y);
  end

endmodule

// File: rtl/sprite_move_ctrl.sv
// rtl/sprite_move_ctrl.sv - clear/load/draw command sequencer for the 4x4 sprite stage
module sprite_move_ctrl
  import sprite_pkg::*;
#(
  parameter int X_INIT = 72,
  parameter int Y_INIT = 52,
  parameter int STEP   = 1,
  parameter int X_MAX  = 156,
  parameter int Y_MAX  = 116
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       complete,
  output logic       draw,
  output logic       clear,
  output logic       shift_h,
  output logic       shift_v,
  output logic       load,
  output logic [6:0] shift_amount,
  output logic [7:0] load_x,
  output logic [6:0] load_y,
  output logic       plot,
  output logic       busy,
  output logic       err
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        next_x;
  logic [6:0]        next_y;
  logic [7:0]        nx;
  logic [6:0]        ny;
  logic              moved;
  logic              in_phase;
  logic              phase_end;
  logic signed [8:0] dx, dy;

  assign dx        = axis_step(move_right, move_left, STEP);
  assign dy        = axis_step(move_down, move_up, STEP);
  assign in_phase  = (state == S_DRAW) || (state == S_CLEAR);
  assign phase_end = in_phase && (cnt == CNT_W'(PHASE_LEN - 1));

  assign busy         = (state != S_IDLE);
  assign shift_v      = 1'b0;
  assign shift_amount = 7'd0;

  sprite_pos_clamp #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_clamp (
    .x     (load_x),
    .y     (load_y),
    .dx    (dx),
    .dy    (dy),
    .nx    (nx),
    .ny    (ny),
    .moved (moved)
  );

  // State register; reset parks in SYNC to realign the free-running sprite pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_SYNC;
    else         state <= state_nxt;
  end

  // Next state plus Moore command decode, so commands are stable at every negedge.
  always_comb begin
    state_nxt = state;
    draw      = 1'b0;
    clear     = 1'b0;
    shift_h   = 1'b0;
    load      = 1'b0;
    plot      = 1'b0;
    case (state)
      S_SYNC: begin
        draw  = 1'b1;
        clear = 1'b1;
        if (complete) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        draw      = 1'b1;
        load      = 1'b1;
        state_nxt = S_DRAW;
      end
      S_DRAW: begin
        draw    = 1'b1;
        shift_h = 1'b1;
        plot    = 1'b1;
        if (phase_end) state_nxt = complete ? S_IDLE : S_SYNC;
      end
      S_CLEAR: begin
        draw  = 1'b1;
        clear = 1'b1;
        plot  = 1'b1;
        if (phase_end) state_nxt = complete ? S_LOAD : S_SYNC;
      end
      S_IDLE: begin
        if (tick && moved) state_nxt = S_CLEAR;
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  // Phase counter, pending/active origin and sticky pointer-misalignment flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      load_x <= 8'(X_INIT);
      load_y <= 7'(Y_INIT);
      next_x <= 8'(X_INIT);
      next_y <= 7'(Y_INIT);
      err    <= 1'b0;
    end else begin
      cnt <= in_phase ? cnt + CNT_W'(1) : '0;
      if (state == S_IDLE && state_nxt == S_CLEAR) begin
        next_x <= nx;
        next_y <= ny;
      end
      if (state != S_LOAD && state_nxt == S_LOAD) begin
        load_x <= next_x;
        load_y <= next_y;
      end
      if (phase_end && !complete) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb/tb_sprite_move_ctrl.sv - scoreboard bench for sprite_move_ctrl with a sprite stage model
module tb_sprite_move_ctrl;

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_SYNC  = 8'b0011_0001;
  localparam logic [7:0] C_LOAD  = 8'b0010_0101;
  localparam logic [7:0] C_DRAW  = 8'b0010_1011;
  localparam logic [7:0] C_CLEAR = 8'b0011_0011;

  logic       clk, resetn, tick;
  logic       move_left, move_right, move_up, move_down;
  logic       complete;
  logic       draw, clear, shift_h, shift_v, load, plot, busy, err;
  logic [6:0] shift_amount;
  logic [7:0] load_x;
  logic [6:0] load_y;

  logic [3:0] ptr;
  logic [3:0] ptr_init;
  logic       ptr_force;
  logic       hold_incomplete;
  logic [7:0] st_x;
  logic [6:0] st_y;

  typedef struct {
    logic [7:0] cmd;
    int         mode;
    int         x;
    int         y;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  int   exp_x;
  int   exp_y;

  sprite_move_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .tick         (tick),
    .move_left    (move_left),
    .move_right   (move_right),
    .move_up      (move_up),
    .move_down    (move_down),
    .complete     (complete),
    .draw         (draw),
    .clear        (clear),
    .shift_h      (shift_h),
    .shift_v      (shift_v),
    .load         (load),
    .shift_amount (shift_amount),
    .load_x       (load_x),
    .load_y       (load_y),
    .plot         (plot),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite stage: no reset, pointer advances on every negedge command except load.
  always @(negedge clk) begin
    if (ptr_force)         ptr <= ptr_init;
    else if (draw && !load) ptr <= ptr + 4'd1;
    if (draw && load) begin
      st_x <= load_x;
      st_y <= load_y;
    end
  end

  assign complete = (ptr == 4'd0) && !hold_incomplete;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic push(input logic [7:0] cmd, input int mode, input int x, input int y);
    exp_t e;
    e.cmd  = cmd;
    e.mode = mode;
    e.x    = x;
    e.y    = y;
    sb.push_back(e);
  endtask

  task automatic push_phase(input logic [7:0] cmd, input int ox, input int oy, input int n);
    for (int i = 0; i < n; i++) push(cmd, 1, ox + i % 4, oy + i / 4);
  endtask

  task automatic push_sync_redraw(input int n_sync, input int ox, input int oy);
    for (int i = 0; i < n_sync; i++) push(C_SYNC, 0, 0, 0);
    push(C_LOAD, 2, ox, oy);
    push_phase(C_DRAW, ox, oy, 16);
    push(C_IDLE, 0, 0, 0);
  endtask

  // Pops one expected entry per negedge and compares commands and coordinates.
  task automatic drain(input string tag, output int busy_cnt);
    exp_t       e;
    logic [7:0] act;
    int         ax, ay;
    bit         ok;
    busy_cnt = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e   = sb.pop_front();
      act = {shift_v, |shift_amount, draw, clear, shift_h, load, plot, busy};
      if (busy) busy_cnt++;
      ok = (act === e.cmd);
      ax = 0;
      ay = 0;
      if (e.mode == 1) begin
        ax = int'(st_x) + int'(ptr[1:0]);
        ay = int'(st_y) + int'(ptr[3:2]);
      end else if (e.mode == 2) begin
        ax = int'(load_x);
        ay = int'(load_y);
      end
      if (e.mode != 0 && (ax != e.x || ay != e.y)) ok = 1'b0;
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: cmd=%b xy=(%0d,%0d) expected cmd=%b xy=(%0d,%0d)",
                 tag, act, ax, ay, e.cmd, e.x, e.y);
      end
    end
  endtask

  task automatic check_int(input string tag, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_cmd"}, int'({shift_v, |shift_amount, draw, clear, shift_h, load, plot, busy}), int'(C_SYNC));
    check_int({tag, "_load_x"}, int'(load_x), 72);
    check_int({tag, "_load_y"}, int'(load_y), 52);
  endtask

  task automatic do_move(input logic l, input logic r, input logic u, input logic d,
                         input logic tk, input string tag);
    int nx, ny, bc;
    bit mv;
    nx = clampi(exp_x + int'(r) - int'(l), 156);
    ny = clampi(exp_y + int'(d) - int'(u), 116);
    mv = tk && (nx != exp_x || ny != exp_y);
    if (mv) begin
      push_phase(C_CLEAR, exp_x, exp_y, 16);
      push_sync_redraw(0, nx, ny);
    end else begin
      for (int i = 0; i < 3; i++) push(C_IDLE, 0, 0, 0);
    end
    move_left  = l;
    move_right = r;
    move_up    = u;
    move_down  = d;
    tick       = tk;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    move_up    = 1'b0;
    move_down  = 1'b0;
    drain(tag, bc);
    check_int({tag, "_busy"}, bc, mv ? 33 : 0);
    if (mv) begin
      exp_x = nx;
      exp_y = ny;
    end
  endtask

  task automatic release_with_ptr7(input string tag);
    int bc;
    resetn    = 1'b0;
    ptr_force = 1'b1;
    ptr_init  = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs({tag, "_in_reset"});
    check_int({tag, "_err_reset"}, int'(err), 0);
    resetn    = 1'b1;
    ptr_force = 1'b0;
    push_sync_redraw(9, 72, 52);
    drain(tag, bc);
    check_int({tag, "_busy"}, bc, 26);
    check_int({tag, "_err"}, int'(err), 0);
    exp_x = 72;
    exp_y = 52;
  endtask

  task automatic test_reset();
    release_with_ptr7("reset");
  endtask

  task automatic test_move_right();
    do_move(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "move_right");
  endtask

  task automatic test_cancel();
    do_move(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "cancel_lr");
    do_move(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "cancel_ud");
    do_move(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "no_tick");
  endtask

  task automatic test_edges();
    while (exp_x > 0 || exp_y > 0) do_move(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "to_origin");
    for (int i = 0; i < 3; i++) do_move(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "origin_hold");
    check_int("origin_x", int'(load_x), 0);
    check_int("origin_y", int'(load_y), 0);
    while (exp_x < 156 || exp_y < 116) do_move(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "to_max");
    do_move(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "max_right");
    do_move(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "max_down");
    do_move(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "max_both");
    check_int("max_x", int'(load_x), 156);
    check_int("max_y", int'(load_y), 116);
  endtask

  task automatic test_reset_mid_draw();
    int bc;
    push_phase(C_CLEAR, exp_x, exp_y, 16);
    push(C_LOAD, 2, exp_x - 1, exp_y);
    push_phase(C_DRAW, exp_x - 1, exp_y, 5);
    move_left = 1'b1;
    tick      = 1'b1;
    @(posedge clk);
    #1;
    move_left = 1'b0;
    tick      = 1'b0;
    drain("mid_draw_pre", bc);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_draw_reset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    push_sync_redraw(9, 72, 52);
    drain("mid_draw_redraw", bc);
    check_int("mid_draw_busy", bc, 26);
    exp_x = 72;
    exp_y = 52;
  endtask

  task automatic test_err();
    int bc;
    hold_incomplete = 1'b1;
    push_phase(C_CLEAR, exp_x, exp_y, 16);
    move_right = 1'b1;
    tick       = 1'b1;
    @(posedge clk);
    #1;
    move_right = 1'b0;
    tick       = 1'b0;
    drain("err_clear", bc);
    @(posedge clk);
    #1;
    check_int("err_set", int'(err), 1);
    check_int("err_sync_cmd", int'({draw, clear, plot, busy}), int'(4'b1101));
    hold_incomplete = 1'b0;
    push_sync_redraw(16, exp_x + 1, exp_y);
    drain("err_resync", bc);
    check_int("err_sticky", int'(err), 1);
    exp_x = exp_x + 1;
    resetn = 1'b0;
    #1;
    check_int("err_cleared", int'(err), 0);
    release_with_ptr7("err_release");
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    resetn          = 1'b0;
    tick            = 1'b0;
    move_left       = 1'b0;
    move_right      = 1'b0;
    move_up         = 1'b0;
    move_down       = 1'b0;
    ptr_force       = 1'b1;
    ptr_init        = 4'd7;
    hold_incomplete = 1'b0;
    exp_x           = 72;
    exp_y           = 52;
    test_reset();
    test_move_right();
    test_cancel();
    test_edges();
    test_reset_mid_draw();
    test_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
